// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detect, oversample tick generation, deserialize, parity/stop check.
// Optional saturating error counter enabled by defining UART_RX_ERR_CNT_EN.
module uart_rx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  data_sample_en,
    output logic [4:0]            edge_count,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic [7:0]            err_count
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state;
    logic [5:0]            prescale_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_flag;
    logic                  stop_flag;

    logic [5:0] ec_ext;
    logic       legal_in;
    logic       start_ok;
    logic       cap;
    logic       pre_last;
    logic       wrap;
    logic       par_bad;
    logic       stop_bad;

    assign ec_ext   = {1'b0, edge_count};
    assign legal_in = (Prescale == 6'd8) || (Prescale == 6'd16) || (Prescale == 6'd32);
    assign start_ok = !RX_IN && legal_in;
    // Voted bit is registered one tick after the last of the three votes around mid-bit.
    assign cap      = (ec_ext == (prescale_q >> 1) + 6'd2);
    assign pre_last = (ec_ext == prescale_q - 6'd2);
    assign wrap     = (ec_ext == prescale_q - 6'd1);
    assign par_bad  = sampled_bit != ((^shift_q) ^ par_typ_q);
    // At Prescale 8 the stop capture and the pulse decision fall on the same tick.
    assign stop_bad = stop_flag || (cap && !sampled_bit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            prescale_q     <= 6'd8;
            par_en_q       <= 1'b0;
            par_typ_q      <= 1'b0;
            bit_cnt        <= '0;
            shift_q        <= '0;
            par_flag       <= 1'b0;
            stop_flag      <= 1'b0;
            data_sample_en <= 1'b0;
            edge_count     <= '0;
            P_DATA         <= '0;
            data_valid     <= 1'b0;
            parity_error   <= 1'b0;
            stop_error     <= 1'b0;
        end else begin
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            edge_count   <= (state == IDLE || wrap) ? 5'd0 : edge_count + 5'd1;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state          <= START;
                        data_sample_en <= 1'b1;
                        prescale_q     <= Prescale;
                        par_en_q       <= PAR_EN;
                        par_typ_q      <= PAR_TYP;
                    end
                end
                START: begin
                    if (cap && sampled_bit) begin
                        state          <= IDLE;
                        data_sample_en <= 1'b0;
                        edge_count     <= '0;
                    end else if (wrap) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (cap) shift_q[bit_cnt] <= sampled_bit;
                    if (wrap) begin
                        if (bit_cnt == LAST_BIT) state <= par_en_q ? PARITY : STOP;
                        else bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (cap && par_bad) par_flag <= 1'b1;
                    if (wrap) state <= STOP;
                end
                STOP: begin
                    if (cap && !sampled_bit) stop_flag <= 1'b1;
                    if (pre_last) begin
                        parity_error <= par_flag;
                        stop_error   <= stop_bad;
                        if (!par_flag && !stop_bad) begin
                            P_DATA     <= shift_q;
                            data_valid <= 1'b1;
                        end
                    end
                    if (wrap) begin
                        par_flag  <= 1'b0;
                        stop_flag <= 1'b0;
                        // A start bit already on the line lets the next frame begin without an idle tick.
                        if (start_ok) begin
                            state      <= START;
                            prescale_q <= Prescale;
                            par_en_q   <= PAR_EN;
                            par_typ_q  <= PAR_TYP;
                        end else begin
                            state          <= IDLE;
                            data_sample_en <= 1'b0;
                        end
                    end
                end
                default: begin
                    state          <= IDLE;
                    data_sample_en <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count <= '0;
        end else if ((parity_error || stop_error) && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: serial frame driver, behavioural majority-vote sampler, pulse scoreboard.
module tb_uart_rx_frame_ctrl;
    localparam int W = 11;

    logic       clk;
    logic       rst;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       sampled_bit;
    logic       data_sample_en;
    logic [4:0] edge_count;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;
    logic [7:0] err_count;

    uart_rx_frame_ctrl #(.DATA_WIDTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .RX_IN          (RX_IN),
        .Prescale       (Prescale),
        .PAR_EN         (PAR_EN),
        .PAR_TYP        (PAR_TYP),
        .sampled_bit    (sampled_bit),
        .data_sample_en (data_sample_en),
        .edge_count     (edge_count),
        .P_DATA         (P_DATA),
        .data_valid     (data_valid),
        .parity_error   (parity_error),
        .stop_error     (stop_error),
        .err_count      (err_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // scoreboard state: {data_valid, parity_error, stop_error, P_DATA}
    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int exp_err = 0;
    int cur_p = 8;
    int rise_cyc = 0;
    int pulse_cyc = 0;
    int pulse_cyc_prev = 0;
    logic dse_prev = 1'b0;
    logic pulse_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // majority-vote sampler standing in for the neighbouring block
    logic s0 = 1'b1;
    logic s1 = 1'b1;
    initial sampled_bit = 1'b1;
    always @(posedge clk) begin
        if (data_sample_en) begin
            if (int'(edge_count) == cur_p / 2 - 1) s0 <= RX_IN;
            if (int'(edge_count) == cur_p / 2) s1 <= RX_IN;
            if (int'(edge_count) == cur_p / 2 + 1)
                sampled_bit <= (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);
        end
    end

    // pulse monitor
    always @(negedge clk) begin
        logic pulse;
        logic [W-1:0] e;
        pulse = data_valid | parity_error | stop_error;
        if (pulse_prev)
            check("pulse_width", 32'({data_valid, parity_error, stop_error}), 32'd0);
        pulse_prev = pulse;
        if (data_sample_en && !dse_prev) rise_cyc = cyc;
        dse_prev = data_sample_en;
        if (pulse) begin
            pulse_cyc_prev = pulse_cyc;
            pulse_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'({data_valid, parity_error, stop_error, P_DATA}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("frame", 32'({data_valid, parity_error, stop_error, P_DATA}), 32'(e));
            end
        end
    end

    // driver tasks
    task automatic send_frame(input logic [7:0] d, input int p, input logic pe,
                              input logic pbit, input logic sbit, input int nbits);
        logic [10:0] bits;
        int total;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (pe) begin
            bits[9]  = pbit;
            bits[10] = sbit;
            total = 11;
        end else begin
            bits[9]  = sbit;
            bits[10] = 1'b1;
            total = 10;
        end
        for (int j = 0; j < total && j < nbits; j++) begin
            RX_IN = bits[j];
            repeat (p) @(negedge clk);
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_err_count(input string tag);
`ifdef UART_RX_ERR_CNT_EN
        check(tag, 32'(err_count), 32'(exp_err));
`else
        check(tag, 32'(err_count), 32'd0);
`endif
    endtask

    initial begin
        rst = 1'b0;
        RX_IN = 1'b1;
        Prescale = 6'd8;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sample_en", 32'(data_sample_en), 32'd0);
        check("rst_edge_count", 32'(edge_count), 32'd0);
        check("rst_p_data", 32'(P_DATA), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_parity_error", 32'(parity_error), 32'd0);
        check("rst_stop_error", 32'(stop_error), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Prescale 8, no parity
        cur_p = 8;
        exp_q.push_back({1'b1, 1'b0, 1'b0, 8'hA5});
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 11);
        drain("drain_a5", 200);
        check("len_p8", 32'(pulse_cyc - rise_cyc + 1), 32'd80);
        repeat (4) @(negedge clk);

        // Prescale 16, even parity good then bad, then odd parity good
        Prescale = 6'd16; cur_p = 16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        exp_q.push_back({1'b1, 1'b0, 1'b0, 8'h3C});
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 11);
        drain("drain_3c_even", 400);
        check("len_p16_par", 32'(pulse_cyc - rise_cyc + 1), 32'd176);
        repeat (4) @(negedge clk);
        exp_q.push_back({1'b0, 1'b1, 1'b0, 8'h3C});
        exp_err++;
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 11);
        drain("drain_3c_bad", 400);
        repeat (4) @(negedge clk);
        PAR_TYP = 1'b1;
        exp_q.push_back({1'b1, 1'b0, 1'b0, 8'h3D});
        send_frame(8'h3D, 16, 1'b1, 1'b0, 1'b1, 11);
        drain("drain_3d_odd", 400);
        repeat (4) @(negedge clk);

        // Prescale 32, stop bit low
        Prescale = 6'd32; cur_p = 32; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 1'b1, 8'h3D});
        exp_err++;
        send_frame(8'h81, 32, 1'b0, 1'b0, 1'b0, 11);
        RX_IN = 1'b1;
        drain("drain_81_stop", 600);
        repeat (2) @(negedge clk);
        check_err_count("err_count_after_errors");
        repeat (40) @(negedge clk);

        // start glitch at Prescale 16
        Prescale = 6'd16; cur_p = 16;
        RX_IN = 1'b0;
        @(negedge clk);
        check("glitch_sample_en_on", 32'(data_sample_en), 32'd1);
        @(negedge clk);
        RX_IN = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch_sample_en_off", 32'(data_sample_en), 32'd0);
        repeat (20) @(negedge clk);

        // illegal prescale keeps the receiver idle
        Prescale = 6'd12;
        RX_IN = 1'b0;
        repeat (16) @(negedge clk);
        check("illegal_prescale_idle", 32'(data_sample_en), 32'd0);
        RX_IN = 1'b1;
        repeat (4) @(negedge clk);

        // back-to-back frames at Prescale 8
        Prescale = 6'd8; cur_p = 8;
        exp_q.push_back({1'b1, 1'b0, 1'b0, 8'h55});
        exp_q.push_back({1'b1, 1'b0, 1'b0, 8'hAA});
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 11);
        send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b1, 11);
        drain("drain_b2b", 300);
        check("b2b_spacing", 32'(pulse_cyc - pulse_cyc_prev), 32'd80);
        repeat (4) @(negedge clk);

        // reset during data bit 4, then a clean frame
        send_frame(8'hF0, 8, 1'b0, 1'b0, 1'b1, 5);
        RX_IN = 1'b1;
        repeat (4) @(negedge clk);
        check("mid_frame_active", 32'(data_sample_en), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_sample_en", 32'(data_sample_en), 32'd0);
        check("mid_rst_edge_count", 32'(edge_count), 32'd0);
        check("mid_rst_p_data", 32'(P_DATA), 32'd0);
        exp_err = 0;
        check_err_count("mid_rst_err_count");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        RX_IN = 1'b1;
        repeat (4) @(negedge clk);
        exp_q.push_back({1'b1, 1'b0, 1'b0, 8'h0F});
        send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b1, 11);
        drain("drain_0f", 200);
        repeat (4) @(negedge clk);
        check("p_data_hold", 32'(P_DATA), 32'h0F);

        drain("final_drain", 10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
